// File: rtl/mips_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mips_ctrl_pkg
// Brief    : State encodings, opcode/funct constants, ALU control codes
// Revision : 1.0 - initial release
// ============================================================================
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'h0,
        S_DECODE   = 4'h1,
        S_MEMADR   = 4'h2,
        S_MEMREAD  = 4'h3,
        S_MEMWB    = 4'h4,
        S_MEMWRITE = 4'h5,
        S_EXECUTE  = 4'h6,
        S_ALUWB    = 4'h7,
        S_BRANCH   = 4'h8,
        S_ADDIEXEC = 4'h9,
        S_ADDIWB   = 4'hA,
        S_JUMP     = 4'hB,
        S_RESET    = 4'hF
    } state_t;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } aluop_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;
    localparam logic [5:0] FUNCT_MUL = 6'b011100;

    localparam logic [2:0] ALU_NONE = 3'b000;
    localparam logic [2:0] ALU_ADD  = 3'b010;
    localparam logic [2:0] ALU_SUB  = 3'b100;
    localparam logic [2:0] ALU_SLT  = 3'b110;
    localparam logic [2:0] ALU_MUL  = 3'b101;

endpackage : mips_ctrl_pkg
`default_nettype wire

// File: rtl/mips_alu_decoder.sv
`default_nettype none
// ============================================================================
// Module   : mips_alu_decoder
// Brief    : Combinational ALUOp/funct to ALUControl translation
// Revision : 1.0 - initial release
// ============================================================================
module mips_alu_decoder
    import mips_ctrl_pkg::*;
(
    input  logic [5:0] i_funct,
    input  aluop_t     i_aluop,
    output logic [2:0] o_alu_control
);

    always_comb begin
        o_alu_control = ALU_ADD;
        case (i_aluop)
            ALUOP_SUB: o_alu_control = ALU_SUB;
            ALUOP_FUNCT: begin
                case (i_funct)
                    FUNCT_SUB: o_alu_control = ALU_SUB;
                    FUNCT_SLT: o_alu_control = ALU_SLT;
                    FUNCT_MUL: o_alu_control = ALU_MUL;
                    default:   o_alu_control = ALU_ADD;
                endcase
            end
            default: o_alu_control = ALU_ADD;
        endcase
    end

endmodule : mips_alu_decoder
`default_nettype wire

// File: rtl/mips_multicycle_controller.sv
`default_nettype none
// ============================================================================
// Module   : mips_multicycle_controller
// Brief    : Multicycle MIPS control FSM (lw/sw/R-type/beq/addi/j)
// Revision : 1.0 - initial release
// ============================================================================
module mips_multicycle_controller
    import mips_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       IorD,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic       PCEn,
    output logic [1:0] ALUSrcB,
    output logic [1:0] PCSrc,
    output logic [2:0] ALUControl,
    output logic [3:0] state_dbg,
    output logic       instr_done
);

    state_t     r_state;
    state_t     w_next;
    aluop_t     w_aluop;
    logic [2:0] w_alu_ctrl;

    mips_alu_decoder u_alu_decoder (
        .i_funct       (funct),
        .i_aluop       (w_aluop),
        .o_alu_control (w_alu_ctrl)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_RESET;
        else        r_state <= w_next;
    end

    assign state_dbg  = r_state;
    // RESET is the only state that drives ALUControl to zero rather than add
    assign ALUControl = (r_state == S_RESET) ? ALU_NONE : w_alu_ctrl;

    always_comb begin
        w_next     = r_state;
        w_aluop    = ALUOP_ADD;
        IorD       = 1'b0;
        MemWrite   = 1'b0;
        IRWrite    = 1'b0;
        RegDst     = 1'b0;
        MemtoReg   = 1'b0;
        RegWrite   = 1'b0;
        ALUSrcA    = 1'b0;
        PCEn       = 1'b0;
        ALUSrcB    = 2'b00;
        PCSrc      = 2'b00;
        instr_done = 1'b0;

        case (r_state)
            S_RESET: w_next = S_FETCH;
            S_FETCH: begin
                ALUSrcB = 2'b01;
                IRWrite = mem_ready;
                PCEn    = mem_ready;
                if (mem_ready) w_next = S_DECODE;
            end
            S_DECODE: begin
                ALUSrcB = 2'b11;
                case (opcode)
                    OP_LW, OP_SW: w_next = S_MEMADR;
                    OP_RTYPE:     w_next = S_EXECUTE;
                    OP_BEQ:       w_next = S_BRANCH;
                    OP_ADDI:      w_next = S_ADDIEXEC;
                    OP_J:         w_next = S_JUMP;
                    default: begin
                        w_next     = S_FETCH;
                        instr_done = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                w_next  = (opcode == OP_SW) ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                IorD = 1'b1;
                if (mem_ready) w_next = S_MEMWB;
            end
            S_MEMWB: begin
                MemtoReg   = 1'b1;
                RegWrite   = 1'b1;
                instr_done = 1'b1;
                w_next     = S_FETCH;
            end
            S_MEMWRITE: begin
                IorD       = 1'b1;
                MemWrite   = 1'b1;
                instr_done = mem_ready;
                if (mem_ready) w_next = S_FETCH;
            end
            S_EXECUTE: begin
                ALUSrcA = 1'b1;
                w_aluop = ALUOP_FUNCT;
                w_next  = S_ALUWB;
            end
            S_ALUWB: begin
                RegDst     = 1'b1;
                RegWrite   = 1'b1;
                instr_done = 1'b1;
                w_next     = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcA    = 1'b1;
                w_aluop    = ALUOP_SUB;
                PCSrc      = 2'b01;
                PCEn       = zero;
                instr_done = 1'b1;
                w_next     = S_FETCH;
            end
            S_ADDIEXEC: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                w_next  = S_ADDIWB;
            end
            S_ADDIWB: begin
                RegWrite   = 1'b1;
                instr_done = 1'b1;
                w_next     = S_FETCH;
            end
            S_JUMP: begin
                PCSrc      = 2'b10;
                PCEn       = 1'b1;
                instr_done = 1'b1;
                w_next     = S_FETCH;
            end
            default: w_next = S_RESET;
        endcase
    end

endmodule : mips_multicycle_controller
`default_nettype wire

// File: tb/tb_mips_multicycle_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_mips_multicycle_controller
// Brief    : Directed scoreboard bench for the multicycle MIPS controller
// Revision : 1.0 - initial release
// ============================================================================
module tb_mips_multicycle_controller;

    localparam logic [2:0] ADD = 3'b010;
    localparam logic [2:0] SUB = 3'b100;
    localparam logic [2:0] SLT = 3'b110;
    localparam logic [2:0] MUL = 3'b101;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;
    logic       IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA, PCEn;
    logic [1:0] ALUSrcB, PCSrc;
    logic [2:0] ALUControl;
    logic [3:0] state_dbg;
    logic       instr_done;

    int total = 0;
    int bad   = 0;
    logic [19:0] q[$];

    mips_multicycle_controller dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .opcode     (opcode),
        .funct      (funct),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .IorD       (IorD),
        .MemWrite   (MemWrite),
        .IRWrite    (IRWrite),
        .RegDst     (RegDst),
        .MemtoReg   (MemtoReg),
        .RegWrite   (RegWrite),
        .ALUSrcA    (ALUSrcA),
        .PCEn       (PCEn),
        .ALUSrcB    (ALUSrcB),
        .PCSrc      (PCSrc),
        .ALUControl (ALUControl),
        .state_dbg  (state_dbg),
        .instr_done (instr_done)
    );

    always #5 clk = ~clk;

    // Observed vector: {state, IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA, PCEn, ALUSrcB, PCSrc, ALUControl, instr_done}
    wire [19:0] w_obs = {state_dbg, IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
                         ALUSrcA, PCEn, ALUSrcB, PCSrc, ALUControl, instr_done};

    function automatic logic [19:0] mk(input logic [3:0] s, input logic [7:0] en,
                                       input logic [1:0] asb, input logic [1:0] pcs,
                                       input logic [2:0] alu, input logic d);
        return {s, en, asb, pcs, alu, d};
    endfunction

    function automatic logic [19:0] e_reset();
        return mk(4'hF, 8'b0000_0000, 2'b00, 2'b00, 3'b000, 1'b0);
    endfunction
    function automatic logic [19:0] e_fetch(input logic rdy);
        return mk(4'h0, {2'b00, rdy, 4'b0000, rdy}, 2'b01, 2'b00, ADD, 1'b0);
    endfunction
    function automatic logic [19:0] e_decode(input logic nop);
        return mk(4'h1, 8'b0000_0000, 2'b11, 2'b00, ADD, nop);
    endfunction

    task automatic chk(input string tag);
        logic [19:0] e;
        e = q.pop_front();
        total++;
        assert (w_obs === e) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, w_obs, e);
        end
    endtask

    task automatic cyc(input string tag, input logic [19:0] e);
        q.push_back(e);
        @(negedge clk);
        chk(tag);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; opcode = 6'd0; funct = 6'd0; zero = 1'b0; mem_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        q.push_back(e_reset());
        chk("reset_hold");
        rst_n = 1'b1;
        cyc("reset_first", e_reset());

        // FETCH waits on memory
        mem_ready = 1'b0;
        cyc("fetch_wait", e_fetch(1'b0));
        mem_ready = 1'b1;

        // lw, zero wait states
        opcode = 6'b100011;
        cyc("lw_fetch",   e_fetch(1'b1));
        cyc("lw_decode",  e_decode(1'b0));
        cyc("lw_memadr",  mk(4'h2, 8'b0000_0010, 2'b10, 2'b00, ADD, 1'b0));
        cyc("lw_memread", mk(4'h3, 8'b1000_0000, 2'b00, 2'b00, ADD, 1'b0));
        cyc("lw_memwb",   mk(4'h4, 8'b0000_1100, 2'b00, 2'b00, ADD, 1'b1));

        // R-type mul, then unknown funct
        opcode = 6'b000000; funct = 6'b011100;
        cyc("mul_fetch",  e_fetch(1'b1));
        cyc("mul_decode", e_decode(1'b0));
        cyc("mul_exec",   mk(4'h6, 8'b0000_0010, 2'b00, 2'b00, MUL, 1'b0));
        cyc("mul_aluwb",  mk(4'h7, 8'b0001_0100, 2'b00, 2'b00, ADD, 1'b1));
        funct = 6'b111111;
        cyc("f3f_fetch",  e_fetch(1'b1));
        cyc("f3f_decode", e_decode(1'b0));
        cyc("f3f_exec",   mk(4'h6, 8'b0000_0010, 2'b00, 2'b00, ADD, 1'b0));
        cyc("f3f_aluwb",  mk(4'h7, 8'b0001_0100, 2'b00, 2'b00, ADD, 1'b1));
        funct = 6'b101010;
        cyc("slt_fetch",  e_fetch(1'b1));
        cyc("slt_decode", e_decode(1'b0));
        cyc("slt_exec",   mk(4'h6, 8'b0000_0010, 2'b00, 2'b00, SLT, 1'b0));
        cyc("slt_aluwb",  mk(4'h7, 8'b0001_0100, 2'b00, 2'b00, ADD, 1'b1));

        // beq taken, then not taken
        opcode = 6'b000100; zero = 1'b1;
        cyc("beq1_fetch",  e_fetch(1'b1));
        cyc("beq1_decode", e_decode(1'b0));
        cyc("beq1_branch", mk(4'h8, 8'b0000_0011, 2'b00, 2'b01, SUB, 1'b1));
        zero = 1'b0;
        cyc("beq0_fetch",  e_fetch(1'b1));
        cyc("beq0_decode", e_decode(1'b0));
        cyc("beq0_branch", mk(4'h8, 8'b0000_0010, 2'b00, 2'b01, SUB, 1'b1));

        // sw with three wait states
        opcode = 6'b101011;
        cyc("sw_fetch",  e_fetch(1'b1));
        cyc("sw_decode", e_decode(1'b0));
        cyc("sw_memadr", mk(4'h2, 8'b0000_0010, 2'b10, 2'b00, ADD, 1'b0));
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++)
            cyc("sw_wait", mk(4'h5, 8'b1100_0000, 2'b00, 2'b00, ADD, 1'b0));
        mem_ready = 1'b1;
        cyc("sw_done",   mk(4'h5, 8'b1100_0000, 2'b00, 2'b00, ADD, 1'b1));

        // addi
        opcode = 6'b001000;
        cyc("addi_fetch",  e_fetch(1'b1));
        cyc("addi_decode", e_decode(1'b0));
        cyc("addi_exec",   mk(4'h9, 8'b0000_0010, 2'b10, 2'b00, ADD, 1'b0));
        cyc("addi_wb",     mk(4'hA, 8'b0000_0100, 2'b00, 2'b00, ADD, 1'b1));

        // j
        opcode = 6'b000010;
        cyc("j_fetch",  e_fetch(1'b1));
        cyc("j_decode", e_decode(1'b0));
        cyc("j_jump",   mk(4'hB, 8'b0000_0001, 2'b00, 2'b10, ADD, 1'b1));

        // unknown opcode behaves as a NOP
        opcode = 6'b111111;
        cyc("nop_fetch",  e_fetch(1'b1));
        cyc("nop_decode", e_decode(1'b1));

        // reset pulse in the middle of a lw memory read
        opcode = 6'b100011;
        cyc("rlw_fetch",  e_fetch(1'b1));
        cyc("rlw_decode", e_decode(1'b0));
        cyc("rlw_memadr", mk(4'h2, 8'b0000_0010, 2'b10, 2'b00, ADD, 1'b0));
        mem_ready = 1'b0;
        cyc("rlw_memread", mk(4'h3, 8'b1000_0000, 2'b00, 2'b00, ADD, 1'b0));
        #1;
        rst_n = 1'b0;
        #1;
        q.push_back(e_reset());
        chk("rst_async");
        @(posedge clk);
        #1;
        q.push_back(e_reset());
        chk("rst_held");
        rst_n = 1'b1;
        mem_ready = 1'b1;
        cyc("rst_release", e_reset());
        cyc("rst_fetch",   e_fetch(1'b1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_mips_multicycle_controller
`default_nettype wire
